// File: rtl/epass_checker.sv
// -----------------------------------------------------------------------------
// epass_checker
//   Toll-account front end for the ETC lane. Parses 3-byte E-pass tag frames
//   (0xA5, ID, 0xA5^ID) from the RFID reader, looks up the account balance,
//   debits TOLL on success and holds a 2-bit verdict until the lane controller
//   acknowledges with `done`.
//
// Ports
//   clk, reset      : system clock, asynchronous active-high reset
//   rx_data/valid   : byte stream from tag reader
//   rx_ready        : byte accepted when rx_valid && rx_ready
//   done            : lane-controller acknowledge, releases verdict in RESULT
//   acct_wr_*       : host account table write port (any state)
//   valid_Epass     : 00 none, 01 paid, 10 rejected, 11 frame error
//   balance_out     : post-debit (or current, on reject) balance
//   busy            : high whenever the FSM is not IDLE
//
// Build option
//   ETC_BLACKLIST_EN : adds acct_wr_blk input and a per-account blacklist bit;
//                      a blacklisted in-range account is always rejected.
// -----------------------------------------------------------------------------
module epass_checker #(
    parameter int NUM_ACCT    = 8,
    parameter int BAL_WIDTH   = 16,
    parameter int TOLL        = 25,
    parameter int TIMEOUT_CYC = 50000,
    localparam int IDX_W      = (NUM_ACCT > 1) ? $clog2(NUM_ACCT) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    input  logic                 done,
    input  logic                 acct_wr_en,
    input  logic [IDX_W-1:0]     acct_wr_idx,
    input  logic [BAL_WIDTH-1:0] acct_wr_bal,
`ifdef ETC_BLACKLIST_EN
    input  logic                 acct_wr_blk,
`endif
    output logic [1:0]           valid_Epass,
    output logic [BAL_WIDTH-1:0] balance_out,
    output logic                 busy
);

    localparam int         CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0] SOF   = 8'hA5;

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_PAID = 2'b01;
    localparam logic [1:0] C_REJ  = 2'b10;
    localparam logic [1:0] C_ERR  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_GET_ID, S_GET_CHK, S_LOOKUP, S_DEDUCT, S_RESULT
    } state_t;

    state_t               r_state, w_next;
    logic [7:0]           r_id;
    logic [CNT_W-1:0]     r_cnt;
    logic [BAL_WIDTH-1:0] r_tbl [NUM_ACCT];
    logic [BAL_WIDTH-1:0] r_newbal;
    logic [1:0]           r_code;
    logic [BAL_WIDTH-1:0] r_bal_out;

    logic                 w_acc;
    logic                 w_tmo;
    logic                 w_chk_ok;
    logic                 w_in_range;
    logic [IDX_W-1:0]     w_idx;
    logic [BAL_WIDTH-1:0] w_cur_bal;
    logic                 w_blk;
    logic                 w_reject;

    assign w_acc      = rx_valid && rx_ready;
    assign w_tmo      = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign w_chk_ok   = (rx_data == (SOF ^ r_id));
    assign w_in_range = ({1'b0, r_id} < 9'(NUM_ACCT));
    assign w_idx      = r_id[IDX_W-1:0];
    assign w_cur_bal  = r_tbl[w_idx];

`ifdef ETC_BLACKLIST_EN
    logic r_blk [NUM_ACCT];
    assign w_blk = r_blk[w_idx];
`else
    assign w_blk = 1'b0;
`endif

    // Out-of-range IDs alias into the table via w_idx; w_in_range gates that.
    assign w_reject = !w_in_range || w_blk || (w_cur_bal < BAL_WIDTH'(TOLL));

    assign valid_Epass = r_code;
    assign balance_out = r_bal_out;
    assign busy        = (r_state != S_IDLE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        rx_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                rx_ready = 1'b1;
                if (w_acc && rx_data == SOF) w_next = S_GET_ID;
            end
            S_GET_ID: begin
                rx_ready = 1'b1;
                if (w_acc)      w_next = S_GET_CHK;
                else if (w_tmo) w_next = S_RESULT;
            end
            S_GET_CHK: begin
                rx_ready = 1'b1;
                if (w_acc)      w_next = w_chk_ok ? S_LOOKUP : S_RESULT;
                else if (w_tmo) w_next = S_RESULT;
            end
            S_LOOKUP: w_next = w_reject ? S_RESULT : S_DEDUCT;
            S_DEDUCT: w_next = S_RESULT;
            S_RESULT: if (done) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_id      <= '0;
            r_cnt     <= '0;
            r_newbal  <= '0;
            r_code    <= C_NONE;
            r_bal_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: r_cnt <= '0;
                S_GET_ID, S_GET_CHK: begin
                    if (w_acc) begin
                        r_cnt <= '0;
                        if (r_state == S_GET_ID) r_id <= rx_data;
                        else if (!w_chk_ok)      r_code <= C_ERR;
                    end else if (w_tmo) begin
                        r_code <= C_ERR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LOOKUP: begin
                    // Debit value is captured here so a host write landing in
                    // this cycle cannot make the DEDUCT subtraction wrap.
                    r_newbal <= w_cur_bal - BAL_WIDTH'(TOLL);
                    if (w_reject) begin
                        r_code    <= C_REJ;
                        r_bal_out <= w_in_range ? w_cur_bal : '0;
                    end
                end
                S_DEDUCT: begin
                    r_code    <= C_PAID;
                    r_bal_out <= r_newbal;
                end
                S_RESULT: if (done) r_code <= C_NONE;
                default: ;
            endcase
        end
    end

    // ---------------- account table ----------------
    // Host write is placed last so it overrides a same-index debit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ACCT; i++) begin
                r_tbl[i] <= '0;
`ifdef ETC_BLACKLIST_EN
                r_blk[i] <= 1'b0;
`endif
            end
        end else begin
            if (r_state == S_DEDUCT) r_tbl[w_idx] <= r_newbal;
            if (acct_wr_en) begin
                r_tbl[acct_wr_idx] <= acct_wr_bal;
`ifdef ETC_BLACKLIST_EN
                r_blk[acct_wr_idx] <= acct_wr_blk;
`endif
            end
        end
    end

endmodule

// File: tb/tb_epass_checker.sv
module tb_epass_checker;
    localparam int NUM_ACCT = 8;
    localparam int BAL_W    = 16;
    localparam int TOLL     = 25;
    localparam int TMO      = 50000;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [7:0]       rx_data = '0;
    logic             rx_valid = 1'b0;
    logic             rx_ready;
    logic             done = 1'b0;
    logic             acct_wr_en = 1'b0;
    logic [2:0]       acct_wr_idx = '0;
    logic [BAL_W-1:0] acct_wr_bal = '0;
`ifdef ETC_BLACKLIST_EN
    logic             acct_wr_blk = 1'b0;
`endif
    logic [1:0]       valid_Epass;
    logic [BAL_W-1:0] balance_out;
    logic             busy;

    epass_checker #(.NUM_ACCT(NUM_ACCT), .BAL_WIDTH(BAL_W), .TOLL(TOLL),
                    .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .done(done), .acct_wr_en(acct_wr_en),
        .acct_wr_idx(acct_wr_idx), .acct_wr_bal(acct_wr_bal),
`ifdef ETC_BLACKLIST_EN
        .acct_wr_blk(acct_wr_blk),
`endif
        .valid_Epass(valid_Epass), .balance_out(balance_out), .busy(busy));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: account balances, blacklist flags, last shown balance.
    int m_bal [NUM_ACCT];
    bit m_blk [NUM_ACCT];
    int m_out = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_ACCT; i++) begin m_bal[i] = 0; m_blk[i] = 0; end
        m_out = 0;
    endtask

    task automatic host_write(input int idx, input int bal, input bit blk);
        acct_wr_en = 1'b1; acct_wr_idx = 3'(idx); acct_wr_bal = BAL_W'(bal);
`ifdef ETC_BLACKLIST_EN
        acct_wr_blk = blk;
`endif
        tick();
        acct_wr_en = 1'b0;
        m_bal[idx] = bal;
`ifdef ETC_BLACKLIST_EN
        m_blk[idx] = blk;
`else
        m_blk[idx] = 0;
        if (blk) m_blk[idx] = 0;
`endif
    endtask

    // Verdict code / latency (cycles after CHK acceptance) from frame rules.
    task automatic model_frame(input int id, input int chk, output int code, output int lat);
        if (chk != (id ^ 'hA5)) begin
            code = 3; lat = 1;
        end else if (id >= NUM_ACCT) begin
            code = 2; lat = 2; m_out = 0;
        end else if (m_blk[id] || m_bal[id] < TOLL) begin
            code = 2; lat = 2; m_out = m_bal[id];
        end else begin
            m_bal[id] -= TOLL; code = 1; lat = 3; m_out = m_bal[id];
        end
    endtask

    task automatic send_byte(input int b);
        rx_data = 8'(b); rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0; rx_data = '0;
    endtask

    task automatic send_frame(input int id, input int chk, input int gap);
        send_byte('hA5); repeat (gap) tick();
        send_byte(id);   repeat (gap) tick();
        send_byte(chk);
    endtask

    // Called one cycle after CHK acceptance; waits (bounded) for a verdict.
    task automatic wait_verdict(input string tag, input int code, input int lat);
        int n = 1;
        while (valid_Epass == 2'b00 && n < 8) begin tick(); n++; end
        check({tag, "_code"}, 32'(valid_Epass), 32'(code));
        check({tag, "_lat"}, n, lat);
        check({tag, "_bal"}, 32'(balance_out), 32'(m_out));
        check({tag, "_busy"}, 32'(busy), 1);
    endtask

    task automatic ack(input string tag);
        done = 1'b1; tick(); done = 1'b0;
        check({tag, "_ack_code"}, 32'(valid_Epass), 0);
        check({tag, "_ack_busy"}, 32'(busy), 0);
    endtask

    task automatic run_frame(input string tag, input int id, input int chk, input int gap);
        int code, lat;
        model_frame(id, chk, code, lat);
        send_frame(id, chk, gap);
        wait_verdict(tag, code, lat);
        ack(tag);
    endtask

    initial begin
        int code, lat, id, chk, gap;
        model_clear();
        #2;
        check("rst_code", 32'(valid_Epass), 0);
        check("rst_bal", 32'(balance_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(rx_ready), 1);
        tick(); reset = 1'b0; tick();

        // Paid, exact-TOLL paid, and low-balance rejection.
        host_write(3, 100, 0);
        run_frame("paid3", 3, 'hA6, 0);
        check("paid3_bal75", 32'(m_out), 75);
        host_write(5, 20, 0);
        run_frame("low5", 5, 'hA0, 0);
        run_frame("low5_again", 5, 'hA0, 0);
        host_write(2, 25, 0);
        run_frame("exact2", 2, 'hA7, 0);

        // Out-of-range ID and bad checksum (no debit).
        run_frame("oor10", 'h0A, 'hAF, 0);
        run_frame("badchk", 3, 'h00, 0);
        run_frame("after_bad", 3, 'hA6, 1);

        // Leading junk is discarded, ID equal to 0xA5 is data not resync.
        send_byte('h00); send_byte('hFF);
        run_frame("junk", 3, 'hA6, 0);
        run_frame("id_a5", 'hA5, 'h00, 0);

        // Timeout: A5 then silence for exactly TMO cycles.
        send_byte('hA5);
        repeat (TMO - 1) tick();
        check("tmo_early_code", 32'(valid_Epass), 0);
        check("tmo_early_busy", 32'(busy), 1);
        tick();
        check("tmo_code", 32'(valid_Epass), 3);
        check("tmo_bal", 32'(balance_out), 32'(m_out));
        ack("tmo");

        // Host write collides with DEDUCT on the same account.
        host_write(3, 60, 0);
        model_frame(3, 'hA6, code, lat);
        send_frame(3, 'hA6, 0);
        tick();
        acct_wr_en = 1'b1; acct_wr_idx = 3'd3; acct_wr_bal = 16'd500;
        tick();
        acct_wr_en = 1'b0;
        m_bal[3] = 500;
        check("coll_code", 32'(valid_Epass), 1);
        check("coll_bal", 32'(balance_out), 35);
        ack("coll");
        run_frame("coll_after", 3, 'hA6, 0);

        // Randomized frames against the model.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0)
                host_write($urandom_range(0, NUM_ACCT - 1), $urandom_range(0, 120), 0);
            id  = $urandom_range(0, 11);
            chk = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 255) : (id ^ 'hA5);
            gap = $urandom_range(0, 3);
            run_frame($sformatf("rnd%0d", k), id, chk, gap);
        end

`ifdef ETC_BLACKLIST_EN
        host_write(1, 1000, 1);
        run_frame("blk_on", 1, 'hA4, 0);
        host_write(1, 1000, 0);
        run_frame("blk_off", 1, 'hA4, 0);
        check("blk_off_bal", 32'(m_out), 975);
`endif

        // Reset while a verdict is held.
        host_write(4, 90, 0);
        model_frame(4, 'hA1, code, lat);
        send_frame(4, 'hA1, 0);
        wait_verdict("pre_rst", code, lat);
        #2 reset = 1'b1;
        #1;
        check("midrst_code", 32'(valid_Epass), 0);
        check("midrst_bal", 32'(balance_out), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_ready", 32'(rx_ready), 1);
        model_clear();
        tick(); reset = 1'b0; tick();
        run_frame("post_rst4", 4, 'hA1, 0);
        run_frame("post_rst3", 3, 'hA6, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/epass_checker.md
Name: epass_checker

Overview:
- Toll-account front end; sits upstream of the ETC lane controller.
- Receives E-pass tag frames from the RFID reader as a byte stream.
- Validates each frame, looks up and debits the account balance, and presents the 2-bit `valid_Epass` verdict the lane controller consumes.
- Holds each verdict until the lane controller acknowledges with `done`.

Parameters:
- NUM_ACCT, 8, number of accounts in internal table; must be a power of 2, max 256.
- BAL_WIDTH, 16, balance width in bits.
- TOLL, 25, fee debited per valid passage (unsigned, < 2^BAL_WIDTH).
- TIMEOUT_CYC, 50000, max idle cycles between bytes inside a frame.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx_data  input  8  byte from tag reader
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  checker can accept byte; byte transfers when rx_valid && rx_ready
- done  input  1  lane-controller acknowledge pulse; releases held verdict
- acct_wr_en  input  1  host account write strobe
- acct_wr_idx  input  log2(NUM_ACCT)  account index to write
- acct_wr_bal  input  BAL_WIDTH  balance to load
- valid_Epass  output  2  verdict: 00 none, 01 paid, 10 rejected, 11 frame error
- balance_out  output  BAL_WIDTH  post-debit balance of last account checked
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, active-high, clears immediately):
  - State=IDLE; valid_Epass=00, balance_out=0, busy=0, rx_ready=1.
  - All account balances=0; timeout counter=0.
- Frame format: 3 bytes — SOF=0xA5, ID, CHK where CHK = 0xA5 ^ ID.
- FSM states: IDLE, GET_ID, GET_CHK, LOOKUP, DEDUCT, RESULT.
- IDLE:
  - rx_ready=1.
  - Accepted byte 0xA5 -> GET_ID.
  - Any other accepted byte is discarded; stay in IDLE.
- GET_ID:
  - rx_ready=1; accepted byte latched as ID -> GET_CHK.
  - A byte equal to 0xA5 here is treated as ID, not as a resync.
- GET_CHK:
  - rx_ready=1.
  - Accepted byte != 0xA5^ID -> RESULT with code 11.
  - Otherwise -> LOOKUP.
- Timeout in GET_ID or GET_CHK:
  - Counter cleared on every accepted byte and on entry to GET_ID.
  - Counter reaching TIMEOUT_CYC-1 without an accepted byte -> RESULT with code 11.
- LOOKUP (1 cycle, rx_ready=0):
  - ID >= NUM_ACCT -> code 10.
  - Balance < TOLL -> code 10.
  - Otherwise -> DEDUCT.
- DEDUCT (1 cycle):
  - balance[ID] <= balance[ID] - TOLL.
  - balance_out <= new value.
  - -> RESULT with code 01.
- Rejection: on code 10 from LOOKUP, balance_out <= current balance (0 if ID out of range); table unchanged.
- Latency: CHK accepted in cycle T -> valid_Epass valid from T+3 (paid) or T+2 (rejected).
  - Frame error shows in the cycle after the failing CHK byte or timeout expiry.
- RESULT:
  - rx_ready=0; valid_Epass held stable.
  - `done`=1 sampled -> valid_Epass<=00, state<=IDLE the next cycle.
  - `done` asserted in any state other than RESULT is ignored.
- Host writes:
  - acct_wr_en writes acct_wr_bal to table[acct_wr_idx] in any state.
  - If a write and the DEDUCT write hit the same index in the same cycle, the host write wins and the debit is lost.
  - The verdict is still 01; balance_out still shows the computed debit value.
- Arithmetic: unsigned BAL_WIDTH compare/subtract; no wrap is possible because the debit requires balance >= TOLL.
- Balance exactly equal to TOLL -> paid; result balance 0.
- Reset mid-frame or in RESULT: immediate return to reset values; partial frame is lost, table cleared.

Optional Feature:
- ETC_BLACKLIST_EN
- Defined:
  - Adds input acct_wr_blk (1 bit), written alongside the balance on acct_wr_en.
  - Adds a per-account blacklist bit, reset to 0.
  - In LOOKUP, a blacklisted in-range ID -> code 10 regardless of balance; no debit.
- Undefined:
  - No port and no storage.
  - Verdict depends only on ID range and balance.

Test Plan:
- Load acct 3 = 100; send A5,03,A6 -> valid_Epass=01 at T+3, balance_out=75, busy=1; pulse done -> 00, IDLE next cycle.
- Load acct 5 = 20; send A5,05,A0 -> code 10, balance_out=20, table[5] stays 20; acct 2 = 25 -> code 01, balance_out=0.
- Send A5,0A,AF (ID 10 >= NUM_ACCT) -> code 10; send A5,03,00 (bad CHK) -> code 11, no debit.
- Send A5 then idle 50000 cycles -> code 11 exactly after TIMEOUT_CYC idle cycles; leading junk 00,FF before A5 is discarded and the frame is still accepted.
- Host writes acct 3 = 500 in the DEDUCT cycle of an acct-3 frame -> code 01 and table[3]=500. Assert reset while in RESULT -> valid_Epass=00 and all balances 0 immediately.
- With ETC_BLACKLIST_EN: acct 1 = 1000, blk=1 -> A5,01,A4 gives code 10, balance unchanged; clear blk -> code 01, balance 975.
